// File: rtl/reg_file_pkg.sv
// Shared constants for the parameterised register file: default geometry
// and the two legal read-latency settings.
package reg_file_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 3;

    localparam int RD_LAT_COMB = 0;
    localparam int RD_LAT_REG  = 1;

endpackage

// File: rtl/reg_file_rdport.sv
// One read port: address mux, zero-register override, and either a
// combinational path or a registered path with write-to-read bypass.
module reg_file_rdport
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int RD_LAT   = RD_LAT_REG
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
    input  logic [(2**ADDR_W)-1:0]                written,
    input  logic                                  we_a,
    input  logic [ADDR_W-1:0]                     addr_a,
    input  logic [DATA_W-1:0]                     data_a,
    input  logic                                  we_b,
    input  logic [ADDR_W-1:0]                     addr_b,
    input  logic [DATA_W-1:0]                     data_b,
    input  logic [ADDR_W-1:0]                     raddr,
    output logic [DATA_W-1:0]                     rdata,
    output logic                                  rvalid
);

    logic              is_zero;
    logic [DATA_W-1:0] cur_data;
    logic              cur_valid;

    assign is_zero = (ZERO_REG != 0) && (raddr == '0);

    always_comb begin
        cur_data  = regs[raddr];
        cur_valid = written[raddr];
        if (is_zero) begin
            cur_data  = '0;
            cur_valid = 1'b1;
        end
    end

    if (RD_LAT == RD_LAT_COMB) begin : g_comb
        assign rdata  = cur_data;
        assign rvalid = cur_valid;
    end else if (RD_LAT == RD_LAT_REG) begin : g_reg
        logic [DATA_W-1:0] nxt_data;
        logic              nxt_valid;

        // Port B is checked first so it wins a same-address dual write,
        // matching what the storage array itself keeps.
        always_comb begin
            nxt_data  = cur_data;
            nxt_valid = cur_valid;
            if (!is_zero) begin
                if (we_b && (addr_b == raddr)) begin
                    nxt_data  = data_b;
                    nxt_valid = 1'b1;
                end else if (we_a && (addr_a == raddr)) begin
                    nxt_data  = data_a;
                    nxt_valid = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rdata  <= '0;
                rvalid <= 1'b0;
            end else begin
                rdata  <= nxt_data;
                rvalid <= nxt_valid;
            end
        end
    end else begin : g_bad_rd_lat
        $fatal(1, "reg_file_rdport: RD_LAT must be 0 or 1");
    end

endmodule

// File: rtl/reg_file_param.sv
// Dual-write, dual-read register file with per-register written flags,
// optional hard-wired zero register and selectable read latency.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int RD_LAT   = RD_LAT_REG
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic [DATA_W-1:0] IN,
    input  logic              WRITE2,
    input  logic [ADDR_W-1:0] IN2ADDRESS,
    input  logic [DATA_W-1:0] IN2,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              OUT1VALID,
    output logic              OUT2VALID,
    output logic              WCOLLIDE
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             written;
    logic                         we_a;
    logic                         we_b;

    // Writes aimed at a hard-wired zero register are dropped here, so they
    // neither commit, bypass, nor count as a collision.
    assign we_a = WRITE  && !((ZERO_REG != 0) && (INADDRESS  == '0));
    assign we_b = WRITE2 && !((ZERO_REG != 0) && (IN2ADDRESS == '0));

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            regs     <= '0;
            written  <= '0;
            WCOLLIDE <= 1'b0;
        end else begin
            if (we_a) begin
                regs[INADDRESS]    <= IN;
                written[INADDRESS] <= 1'b1;
            end
            if (we_b) begin
                regs[IN2ADDRESS]    <= IN2;
                written[IN2ADDRESS] <= 1'b1;
            end
            WCOLLIDE <= we_a && we_b && (INADDRESS == IN2ADDRESS);
        end
    end

    reg_file_rdport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .RD_LAT   (RD_LAT)
    ) u_rd1 (
        .clk     (CLK),
        .reset_n (RESET),
        .regs    (regs),
        .written (written),
        .we_a    (we_a),
        .addr_a  (INADDRESS),
        .data_a  (IN),
        .we_b    (we_b),
        .addr_b  (IN2ADDRESS),
        .data_b  (IN2),
        .raddr   (OUT1ADDRESS),
        .rdata   (OUT1),
        .rvalid  (OUT1VALID)
    );

    reg_file_rdport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .RD_LAT   (RD_LAT)
    ) u_rd2 (
        .clk     (CLK),
        .reset_n (RESET),
        .regs    (regs),
        .written (written),
        .we_a    (we_a),
        .addr_a  (INADDRESS),
        .data_a  (IN),
        .we_b    (we_b),
        .addr_b  (IN2ADDRESS),
        .data_b  (IN2),
        .raddr   (OUT2ADDRESS),
        .rdata   (OUT2),
        .rvalid  (OUT2VALID)
    );

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: three configurations share one stimulus stream
// and are checked against an array model plus hand-computed values.
module tb_reg_file_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr  = 1'b0;
    logic       wr2 = 1'b0;
    logic [2:0] a   = '0;
    logic [2:0] a2  = '0;
    logic [7:0] din  = '0;
    logic [7:0] din2 = '0;
    logic [2:0] ra1 = '0;
    logic [2:0] ra2 = '0;

    logic [7:0] l1_o1, l1_o2, l0_o1, l0_o2, z_o1, z_o2;
    logic       l1_v1, l1_v2, l0_v1, l0_v2, z_v1, z_v2;
    logic       l1_c, l0_c, z_c;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    // Model: storage after each edge, plus the registered outputs it implies.
    logic [7:0] m_mem [8];
    bit         m_wr  [8];
    logic [7:0] zm_mem[8];
    bit         zm_wr [8];
    logic [7:0] e1_o1, e1_o2, ez_o1, ez_o2;
    bit         e1_v1, e1_v2, ez_v1, ez_v2;
    bit         e_c, ez_c;

    always #5 clk = ~clk;

    reg_file_param u_l1 (
        .CLK(clk), .RESET(rst), .WRITE(wr), .INADDRESS(a), .IN(din),
        .WRITE2(wr2), .IN2ADDRESS(a2), .IN2(din2),
        .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2),
        .OUT1(l1_o1), .OUT2(l1_o2), .OUT1VALID(l1_v1), .OUT2VALID(l1_v2),
        .WCOLLIDE(l1_c)
    );

    reg_file_param #(.RD_LAT(0)) u_l0 (
        .CLK(clk), .RESET(rst), .WRITE(wr), .INADDRESS(a), .IN(din),
        .WRITE2(wr2), .IN2ADDRESS(a2), .IN2(din2),
        .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2),
        .OUT1(l0_o1), .OUT2(l0_o2), .OUT1VALID(l0_v1), .OUT2VALID(l0_v2),
        .WCOLLIDE(l0_c)
    );

    reg_file_param #(.ZERO_REG(1), .RD_LAT(1)) u_z (
        .CLK(clk), .RESET(rst), .WRITE(wr), .INADDRESS(a), .IN(din),
        .WRITE2(wr2), .IN2ADDRESS(a2), .IN2(din2),
        .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2),
        .OUT1(z_o1), .OUT2(z_o2), .OUT1VALID(z_v1), .OUT2VALID(z_v2),
        .WCOLLIDE(z_c)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge and update the model from the inputs the DUT sampled.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[i] = '0; m_wr[i] = 1'b0; zm_mem[i] = '0; zm_wr[i] = 1'b0;
            end
            e1_o1 = '0; e1_o2 = '0; e1_v1 = 1'b0; e1_v2 = 1'b0;
            ez_o1 = '0; ez_o2 = '0; ez_v1 = 1'b0; ez_v2 = 1'b0;
            e_c = 1'b0; ez_c = 1'b0;
        end else begin
            e_c  = wr && wr2 && (a == a2);
            ez_c = e_c && (a != 3'd0);
            if (wr)  begin m_mem[a]  = din;  m_wr[a]  = 1'b1; end
            if (wr2) begin m_mem[a2] = din2; m_wr[a2] = 1'b1; end
            if (wr  && a  != 3'd0) begin zm_mem[a]  = din;  zm_wr[a]  = 1'b1; end
            if (wr2 && a2 != 3'd0) begin zm_mem[a2] = din2; zm_wr[a2] = 1'b1; end
            e1_o1 = m_mem[ra1]; e1_v1 = m_wr[ra1];
            e1_o2 = m_mem[ra2]; e1_v2 = m_wr[ra2];
            ez_o1 = (ra1 == 3'd0) ? 8'h00 : zm_mem[ra1];
            ez_v1 = (ra1 == 3'd0) ? 1'b1  : zm_wr[ra1];
            ez_o2 = (ra2 == 3'd0) ? 8'h00 : zm_mem[ra2];
            ez_v2 = (ra2 == 3'd0) ? 1'b1  : zm_wr[ra2];
        end
        started = 1'b1;
        #1;
    endtask

    task automatic idle();
        wr = 1'b0; wr2 = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("l1_out1",  l1_o1, e1_o1);
                chk("l1_out2",  l1_o2, e1_o2);
                chk("l1_val1",  {7'd0, l1_v1}, {7'd0, e1_v1});
                chk("l1_val2",  {7'd0, l1_v2}, {7'd0, e1_v2});
                chk("l1_coll",  {7'd0, l1_c},  {7'd0, e_c});
                chk("l0_out1",  l0_o1, m_mem[ra1]);
                chk("l0_out2",  l0_o2, m_mem[ra2]);
                chk("l0_val1",  {7'd0, l0_v1}, {7'd0, m_wr[ra1]});
                chk("l0_val2",  {7'd0, l0_v2}, {7'd0, m_wr[ra2]});
                chk("l0_coll",  {7'd0, l0_c},  {7'd0, e_c});
                chk("z_out1",   z_o1, ez_o1);
                chk("z_out2",   z_o2, ez_o2);
                chk("z_val1",   {7'd0, z_v1}, {7'd0, ez_v1});
                chk("z_val2",   {7'd0, z_v2}, {7'd0, ez_v2});
                chk("z_coll",   {7'd0, z_c},  {7'd0, ez_c});
            end
        end
    end

    initial begin
        // Reset for one edge, then sweep every address on both ports.
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i); ra2 = 3'(7 - i);
            step();
            chk("rst_l1_out1", l1_o1, 8'h00);
            chk("rst_l1_val1", {7'd0, l1_v1}, 8'h00);
            chk("rst_l0_out2", l0_o2, 8'h00);
            chk("rst_l0_val2", {7'd0, l0_v2}, 8'h00);
        end

        // Single write with the read address held on the target.
        wr = 1'b1; a = 3'd3; din = 8'h5A; ra1 = 3'd3;
        #1;
        chk("lat0_before_edge", l0_o1, 8'h00);
        step();
        idle();
        chk("bypass_out1", l1_o1, 8'h5A);
        chk("bypass_val1", {7'd0, l1_v1}, 8'h01);
        chk("lat0_after_edge", l0_o1, 8'h5A);

        // Same-address dual write: port B wins, collision pulse lasts one cycle.
        wr = 1'b1; wr2 = 1'b1; a = 3'd5; a2 = 3'd5; din = 8'h11; din2 = 8'h22; ra1 = 3'd5;
        step();
        idle();
        chk("coll_data", l1_o1, 8'h22);
        chk("coll_pulse", {7'd0, l1_c}, 8'h01);
        step();
        chk("coll_drop", {7'd0, l1_c}, 8'h00);
        chk("coll_hold", l0_o1, 8'h22);

        // Distinct dual write.
        wr = 1'b1; wr2 = 1'b1; a = 3'd1; a2 = 3'd6; din = 8'hAA; din2 = 8'hBB;
        ra1 = 3'd1; ra2 = 3'd6;
        step();
        idle();
        chk("dual_out1", l1_o1, 8'hAA);
        chk("dual_out2", l1_o2, 8'hBB);
        chk("dual_coll", {7'd0, l1_c}, 8'h00);

        // Both read ports on one address.
        ra1 = 3'd6; ra2 = 3'd6;
        step();
        chk("same_rd1", l1_o1, 8'hBB);
        chk("same_rd2", l1_o2, 8'hBB);

        // Zero register: writes to address 0 are ignored, even when colliding.
        wr = 1'b1; a = 3'd0; din = 8'hFF; ra1 = 3'd0;
        step();
        idle();
        chk("zero_out1", z_o1, 8'h00);
        chk("zero_val1", {7'd0, z_v1}, 8'h01);
        chk("zero_plain", l1_o1, 8'hFF);
        wr = 1'b1; wr2 = 1'b1; a = 3'd0; a2 = 3'd0; din = 8'h12; din2 = 8'h34;
        step();
        idle();
        chk("zero_coll", {7'd0, z_c}, 8'h00);
        chk("plain_coll0", {7'd0, l1_c}, 8'h01);

        // Reset on the same edge as a write discards the write.
        rst = 1'b0; wr = 1'b1; a = 3'd2; din = 8'h77; ra1 = 3'd2;
        step();
        rst = 1'b1; idle();
        step();
        chk("rstmid_out1", l1_o1, 8'h00);
        chk("rstmid_val1", {7'd0, l1_v1}, 8'h00);
        chk("rstmid_l0", l0_o1, 8'h00);
        wr = 1'b1; a = 3'd2; din = 8'h77;
        step();
        idle();
        chk("post_rst_wr", l1_o1, 8'h77);
        chk("post_rst_val", {7'd0, l1_v1}, 8'h01);

        // A few mixed writes and reads left to the model.
        for (int i = 0; i < 8; i++) begin
            wr = 1'(i % 2); wr2 = 1'((i / 2) % 2);
            a = 3'(i); a2 = 3'(7 - i);
            din = 8'(8'h30 + i); din2 = 8'(8'hC0 + i);
            ra1 = 3'(i + 1); ra2 = 3'(7 - i);
            step();
        end
        idle();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
